regfile_mp: RTL and testbench



---
 rtl/regfile_mp_pkg.sv | 16 +
 rtl/regfile_mp_dump_fsm.sv | 74 +++++++
 rtl/regfile_mp.sv | 90 +++++++++
 tb/tb_regfile_mp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for regfile_mp: dump FSM state encodings and default geometry.
// Optional same-cycle write forwarding is enabled by defining RF_BYPASS_EN.
package regfile_mp_pkg;

  typedef enum logic [1:0] {
    RF_IDLE = 2'd0,
    RF_SCAN = 2'd1,
    RF_DONE = 2'd2
  } rf_state_t;

  localparam int RF_DEF_DATA_W = 32;
  localparam int RF_DEF_ADDR_W = 5;
  localparam int RF_DEF_NUM_RD = 2;
  localparam int RF_MAX_RD     = 4;

endpackage

// File: rtl/regfile_mp_dump_fsm.sv
// Dump sequencer: walks every register index once over a valid/ready handshake,
// then emits a single-cycle done pulse. The top module turns dump_addr into data.
module rf_dump_fsm
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = RF_DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dump_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  rf_state_t         state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RF_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    dump_busy  = 1'b0;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    unique case (state)
      RF_IDLE: begin
        if (dump_req) begin
          state_next = RF_SCAN;
          ptr_next   = '0;
        end
      end
      RF_SCAN: begin
        dump_busy  = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          // Park the pointer at 0 after the last beat instead of wrapping,
          // so dump_addr idles at 0 just as it does out of reset.
          if (ptr == LAST_ADDR) begin
            state_next = RF_DONE;
            ptr_next   = '0;
          end else begin
            ptr_next = ptr + 1'b1;
          end
        end
      end
      RF_DONE: begin
        dump_busy  = 1'b1;
        dump_done  = 1'b1;
        state_next = RF_IDLE;
      end
      default: begin
        state_next = RF_IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  assign dump_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a built-in dump engine.
// Define RF_BYPASS_EN to forward same-cycle write data to reads and dump_data.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DEF_DATA_W,
  parameter int ADDR_W   = RF_DEF_ADDR_W,
  parameter int NUM_RD   = RF_DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     dump_req,
  output logic                     dump_busy,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int NUM_PORTS = NUM_RD + 1;

  generate
    if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD must be in 1..4");
    end
  endgenerate

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_allowed;

  assign wr_allowed = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_allowed) begin
      regs[wr_addr] <= wr_data;
    end
  end

  rf_dump_fsm #(.ADDR_W(ADDR_W)) u_dump (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .dump_addr  (dump_addr)
  );

  // The dump engine is simply one more read port stacked above the user ports,
  // so it shares the zero-register masking and optional forwarding.
  logic [NUM_PORTS*ADDR_W-1:0] mux_addr;
  logic [NUM_PORTS*DATA_W-1:0] mux_data;

  assign mux_addr = {dump_addr, rd_addr};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] value;

      assign addr = mux_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        value = regs[addr];
`ifdef RF_BYPASS_EN
        if (wr_en && (wr_addr == addr)) value = wr_data;
`endif
        if ((ZERO_REG != 0) && (addr == '0)) value = '0;
      end

      assign mux_data[gi*DATA_W +: DATA_W] = value;
    end
  endgenerate

  assign rd_data   = mux_data[NUM_RD*DATA_W-1:0];
  assign dump_data = mux_data[NUM_RD*DATA_W +: DATA_W];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: reads, writes, zero register,
// write/read ordering, full dump with back-pressure, and reset mid-dump.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            dump_req = 1'b0;
  logic            dump_ready = 1'b0;
  logic            dump_busy, dump_valid, dump_done;
  logic [AW-1:0]   dump_addr;
  logic [DW-1:0]   dump_data;

  // Second instance with an ordinary register 0, sharing the write bus.
  logic [AW-1:0]   z_rd_addr = '0;
  logic [DW-1:0]   z_rd_data;
  logic            z_busy, z_valid, z_done;
  logic [AW-1:0]   z_dump_addr;
  logic [DW-1:0]   z_dump_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(1), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .rd_addr(z_rd_addr), .rd_data(z_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_req(1'b0), .dump_busy(z_busy), .dump_valid(z_valid),
    .dump_ready(1'b0), .dump_addr(z_dump_addr), .dump_data(z_dump_data),
    .dump_done(z_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] port(input int k);
    logic [NR*DW-1:0] v;
    v = rd_data;
    return v[k*DW +: DW];
  endfunction

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  int idx, last_cyc, done_cnt, injected;

  initial begin
    // Reset state
    #2;
    check("rst_busy", 64'(dump_busy), 64'd0);
    check("rst_valid", 64'(dump_valid), 64'd0);
    check("rst_done", 64'(dump_done), 64'd0);
    check("rst_addr", 64'(dump_addr), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < NR; k++) set_rd(k, AW'(k + 5));
    #1;
    for (int k = 0; k < NR; k++) check($sformatf("rst_rd%0d", k), 64'(port(k)), 64'd0);

    // Basic write then read
    set_rd(0, 5);
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    #1;
`ifdef RF_BYPASS_EN
    check("r5_same_cycle", 64'(port(0)), 64'hDEADBEEF);
`else
    check("r5_same_cycle", 64'(port(0)), 64'h0);
`endif
    step();
    wr_en = 1'b0;
    check("r5_after", 64'(port(0)), 64'hDEADBEEF);

    // Register 0 behaviour on both instances
    write_reg(0, 32'h12345678);
    set_rd(0, 0); z_rd_addr = 0;
    #1;
    check("r0_zero_reg", 64'(port(0)), 64'h0);
    check("r0_plain", 64'(z_rd_data), 64'h12345678);

    // Four simultaneous reads
    for (int i = 1; i <= 4; i++) write_reg(AW'(i), DW'(i));
    rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    for (int k = 0; k < NR; k++) check($sformatf("rd4_port%0d", k), 64'(port(k)), 64'(k + 1));
    check("rd4_top_port", 64'(port(3)), 64'd4);

    // Same-cycle write/read of r7
    write_reg(7, 32'd9);
    set_rd(0, 7);
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'd11;
    #1;
`ifdef RF_BYPASS_EN
    check("r7_same_cycle", 64'(port(0)), 64'd11);
`else
    check("r7_same_cycle", 64'(port(0)), 64'd9);
`endif
    step();
    wr_en = 1'b0;
    check("r7_next_cycle", 64'(port(0)), 64'd11);

    // Full dump with toggling ready and a stray request mid-scan
    for (int i = 0; i < 32; i++) write_reg(AW'(i), DW'(i));
    dump_req = 1'b1; dump_ready = 1'b1;
    step();
    dump_req = 1'b0;
    idx = 0; last_cyc = -10; done_cnt = 0; injected = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (dump_valid) begin
        check($sformatf("dump_addr_c%0d", cyc), 64'(dump_addr), 64'(idx));
        if (dump_ready) begin
          check($sformatf("dump_data_b%0d", idx), 64'(dump_data), 64'(idx));
          idx++;
          last_cyc = cyc;
        end
      end
      if (dump_done) begin
        done_cnt++;
        check("done_latency", 64'(cyc - last_cyc), 64'd1);
        check("done_busy", 64'(dump_busy), 64'd1);
        break;
      end
      @(posedge clk); #1;
      dump_ready = ~dump_ready;
      dump_req = (idx == 16 && injected == 0);
      if (dump_req) injected = 1;
    end
    check("dump_beats", 64'(idx), 64'd32);
    check("dump_done_cnt", 64'(done_cnt), 64'd1);
    step();
    dump_req = 1'b0;
    #1;
    check("post_dump_busy", 64'(dump_busy), 64'd0);
    check("post_dump_done", 64'(dump_done), 64'd0);

    // Reset in the middle of a dump
    dump_ready = 1'b1; dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 100 && idx < 10; cyc++) begin
      @(negedge clk);
      if (dump_valid && dump_ready) idx++;
    end
    check("abort_beats", 64'(idx), 64'd10);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(dump_valid), 64'd0);
    check("abort_busy", 64'(dump_busy), 64'd0);
    check("abort_addr", 64'(dump_addr), 64'd0);
    step();
    check("abort_no_done", 64'(dump_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_addr = {5'd31, 5'd7, 5'd5, 5'd3};
    #1;
    for (int k = 0; k < NR; k++) check($sformatf("abort_rd%0d", k), 64'(port(k)), 64'd0);
    check("abort_done_after", 64'(dump_done), 64'd0);

    // Fresh dump starts at index 0
    step();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    check("restart_valid", 64'(dump_valid), 64'd1);
    check("restart_addr", 64'(dump_addr), 64'd0);
    done_cnt = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (dump_done) begin
        done_cnt++;
        break;
      end
    end
    check("restart_done", 64'(done_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
